// File: rtl/burst_line_adapter.sv
// Cache-line to memory-burst adapter: turns one line fill/writeback request into
// BEATS memory beats and reports completion with a single resp_valid pulse.
module burst_line_adapter #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LINE_BITS-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [ADDR_BITS-1:0] resp_addr,
    output logic [LINE_BITS-1:0] resp_rdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BEAT_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [BEAT_BITS-1:0] mem_rdata
);

    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CW    = $clog2(BEATS);
    localparam int BOFF  = $clog2(BEAT_BITS);
    localparam logic [CW-1:0]        LAST_BEAT = CW'(BEATS - 1);
    localparam logic [ADDR_BITS-1:0] LINE_MASK = ADDR_BITS'((LINE_BITS / 8) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_BEAT = 3'd2,
        WR_BEAT = 3'd3,
        DONE    = 3'd4,
        DRAIN   = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   write_q, write_d;
    logic [LINE_BITS-1:0]   line_q, line_d;

    // Bit offset of the current beat inside the line (beat width is a power of two).
    logic [CW+BOFF-1:0]     beat_base;
    assign beat_base = {cnt_q, BOFF'(0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        line_d     = line_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                req_ready = !flush && !rst;
                if (req_valid && !flush) begin
                    // The one line buffer holds the writeback data or collects the fill.
                    addr_d  = req_addr & ~LINE_MASK;
                    write_d = req_write;
                    line_d  = req_wdata;
                    cnt_d   = '0;
                    state_d = req_write ? WR_BEAT : RD_REQ;
                end
            end

            RD_REQ: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_ready) begin
                    state_d = RD_BEAT;
                end
            end

            RD_BEAT: begin
                if (mem_rvalid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!flush) begin
                        line_d[beat_base +: BEAT_BITS] = mem_rdata;
                    end
                end
                // A beat arriving with the flush still counts toward the burst length.
                if (flush) begin
                    state_d = (mem_rvalid && cnt_q == LAST_BEAT) ? IDLE : DRAIN;
                end else if (mem_rvalid && cnt_q == LAST_BEAT) begin
                    state_d = DONE;
                end
            end

            WR_BEAT: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = line_q[beat_base +: BEAT_BITS];
                if (mem_ready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                resp_valid = write_q || !flush;
                state_d    = IDLE;
            end

            DRAIN: begin
                // Memory still owes the rest of the burst; swallow it without touching the buffer.
                if (mem_rvalid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Last completed (or partially filled) line stays visible between requests.
    assign resp_addr  = addr_q;
    assign resp_rdata = line_q;

endmodule

// File: tb/tb_burst_line_adapter.sv
// Directed bench for burst_line_adapter: default 256/64 instance plus a 512/32 sweep
// instance, with hand-computed expected lines, beat order and latencies.
module tb_burst_line_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [255:0] req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_addr;
    logic [255:0] resp_rdata;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [63:0]  mem_wdata;
    logic         mem_ready;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;

    logic         w_req_valid;
    logic         w_req_ready;
    logic [31:0]  w_req_addr;
    logic         w_resp_valid;
    logic [31:0]  w_resp_addr;
    logic [511:0] w_resp_rdata;
    logic [31:0]  w_mem_addr;
    logic         w_mem_read;
    logic         w_mem_write;
    logic [31:0]  w_mem_wdata;
    logic         w_mem_ready;
    logic         w_mem_rvalid;
    logic [31:0]  w_mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int resp_cnt = 0;
    int w_resp_cnt = 0;
    int prot_err = 0;
    logic [63:0] exp_q[$];

    burst_line_adapter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_addr(resp_addr), .resp_rdata(resp_rdata),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    burst_line_adapter #(.LINE_BITS(512), .BEAT_BITS(32), .ADDR_BITS(32)) u_wide (
        .clk(clk), .rst(rst), .flush(1'b0),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(1'b0),
        .req_addr(w_req_addr), .req_wdata(512'd0),
        .resp_valid(w_resp_valid), .resp_addr(w_resp_addr), .resp_rdata(w_resp_rdata),
        .mem_addr(w_mem_addr), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .mem_wdata(w_mem_wdata), .mem_ready(w_mem_ready),
        .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: completion pulses, read/write exclusivity, write-beat scoreboard.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) resp_cnt++;
        if (w_resp_valid === 1'b1) w_resp_cnt++;
        if ((mem_read && mem_write) === 1'b1) prot_err++;
        if ((w_mem_read && w_mem_write) === 1'b1) prot_err++;
        if (rst === 1'b0 && mem_write === 1'b1 && mem_ready === 1'b1) begin
            if (exp_q.size() == 0) check_eq("wbeat_extra", 512'(1), 512'(0));
            else check_eq("wbeat", 512'(mem_wdata), 512'(exp_q.pop_front()));
        end
    end

    // Driver tasks
    task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input logic [255:0] wd);
        int acc;
        int n0;
        n0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = wd;
        #1 check_eq("rd_req_ready", 512'(req_ready), 512'(1));
        acc = cyc;
        tick();
        req_valid = 1'b0; mem_ready = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = {16{4'hE}};
        #1;
        check_eq("rd_mem_read", 512'(mem_read), 512'(1));
        check_eq("rd_mem_write", 512'(mem_write), 512'(0));
        check_eq("rd_mem_addr", 512'(mem_addr), 512'(addr & ~32'h1F));
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = line[i*64 +: 64];
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        check_eq("rd_resp_valid", 512'(resp_valid), 512'(1));
        check_eq("rd_resp_addr", 512'(resp_addr), 512'(addr & ~32'h1F));
        check_eq("rd_resp_rdata", 512'(resp_rdata), 512'(line));
        check_eq("rd_latency", 512'(cyc - acc), 512'(6));
        tick();
        check_eq("rd_resp_pulse", 512'(resp_valid), 512'(0));
        check_eq("rd_ready_after", 512'(req_ready), 512'(1));
        check_eq("rd_resp_count", 512'(resp_cnt), 512'(n0 + 1));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int stall_beat, input int stall_len, input logic fl);
        int acc;
        int n0;
        n0 = resp_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(line[i*64 +: 64]);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = line;
        #1 check_eq("wr_req_ready", 512'(req_ready), 512'(1));
        acc = cyc;
        tick();
        req_valid = 1'b0; flush = fl;
        for (int b = 0; b < 4; b++) begin
            if (b == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    mem_ready = 1'b0;
                    #1 check_eq("wr_hold", 512'(mem_wdata), 512'(line[b*64 +: 64]));
                    tick();
                end
            end
            mem_ready = 1'b1;
            #1;
            check_eq("wr_mem_write", 512'(mem_write), 512'(1));
            check_eq("wr_mem_read", 512'(mem_read), 512'(0));
            check_eq("wr_mem_addr", 512'(mem_addr), 512'(addr & ~32'h1F));
            tick();
        end
        mem_ready = 1'b0;
        #1;
        check_eq("wr_resp_valid", 512'(resp_valid), 512'(1));
        check_eq("wr_resp_addr", 512'(resp_addr), 512'(addr & ~32'h1F));
        check_eq("wr_resp_rdata", 512'(resp_rdata), 512'(line));
        check_eq("wr_latency", 512'(cyc - acc), 512'(5 + stall_len));
        tick();
        flush = 1'b0;
        #1;
        check_eq("wr_resp_pulse", 512'(resp_valid), 512'(0));
        check_eq("wr_resp_count", 512'(resp_cnt), 512'(n0 + 1));
    endtask

    task automatic do_wide_read(input logic [31:0] addr, input logic [31:0] mult);
        logic [511:0] exp_line;
        int acc;
        int n0;
        n0 = w_resp_cnt;
        for (int i = 0; i < 16; i++) exp_line[i*32 +: 32] = 32'(i + 1) * mult;
        w_req_valid = 1'b1; w_req_addr = addr;
        #1 check_eq("w_req_ready", 512'(w_req_ready), 512'(1));
        acc = cyc;
        tick();
        w_req_valid = 1'b0; w_mem_ready = 1'b1;
        #1 check_eq("w_mem_addr", 512'(w_mem_addr), 512'(addr & ~32'h3F));
        tick();
        w_mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_mem_rvalid = 1'b1; w_mem_rdata = 32'(i + 1) * mult;
            tick();
        end
        w_mem_rvalid = 1'b0;
        #1;
        check_eq("w_resp_valid", 512'(w_resp_valid), 512'(1));
        check_eq("w_resp_addr", 512'(w_resp_addr), 512'(addr & ~32'h3F));
        check_eq("w_resp_rdata", w_resp_rdata, exp_line);
        check_eq("w_latency", 512'(cyc - acc), 512'(18));
        tick();
        check_eq("w_resp_count", 512'(w_resp_cnt), 512'(n0 + 1));
    endtask

    logic [255:0] line_a, line_b, line_c, wline, pat, exp_l;
    logic [63:0]  r0, r1, r2, r3;
    int n0;

    initial begin
        rst = 1'b1; flush = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        w_req_valid = 1'b0; w_req_addr = '0;
        w_mem_ready = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = '0;
        r0 = {16{4'h1}}; r1 = {16{4'h2}}; r2 = {16{4'h3}}; r3 = {16{4'h4}};
        line_a = {r3, r2, r1, r0};
        wline  = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                  64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        pat    = {16{16'hC0DE}};
        line_b = {64'h0BB3_0BB3_0BB3_0BB3, 64'h0BB2_0BB2_0BB2_0BB2,
                  64'h0BB1_0BB1_0BB1_0BB1, 64'h0BB0_0BB0_0BB0_0BB0};
        line_c = {64'hCC03_CC03_CC03_CC03, 64'hCC02_CC02_CC02_CC02,
                  64'hCC01_CC01_CC01_CC01, 64'hCC00_CC00_CC00_CC00};

        // Reset state
        tick();
        tick();
        check_eq("rst_req_ready", 512'(req_ready), 512'(0));
        check_eq("rst_resp_valid", 512'(resp_valid), 512'(0));
        check_eq("rst_mem_read", 512'(mem_read), 512'(0));
        check_eq("rst_mem_write", 512'(mem_write), 512'(0));
        check_eq("rst_resp_rdata", 512'(resp_rdata), 512'(0));
        check_eq("rst_resp_addr", 512'(resp_addr), 512'(0));
        rst = 1'b0;
        tick();
        check_eq("post_rst_ready", 512'(req_ready), 512'(1));

        // Basic fill, then writebacks (plain, stalled on 2nd beat, under flush)
        do_read(32'h1000_0013, line_a, 256'd0);
        do_write(32'h2000_0045, wline, 4, 0, 1'b0);
        do_write(32'h2000_0045, wline, 1, 3, 1'b0);
        do_write(32'h2000_00A0, ~wline, 2, 1, 1'b1);

        // Flush after two beats: remaining two beats absorbed, buffer keeps the first two
        n0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3000_0020; req_wdata = pat;
        tick();
        req_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = r0; tick();
        mem_rdata = r1; tick();
        mem_rvalid = 1'b0; flush = 1'b1;
        #1 check_eq("drain_flush_ready", 512'(req_ready), 512'(0));
        tick();
        flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = r2;
        #1 check_eq("drain_mem_read", 512'(mem_read), 512'(0));
        tick();
        mem_rdata = r3;
        #1 check_eq("drain_busy", 512'(req_ready), 512'(0));
        tick();
        mem_rvalid = 1'b0;
        exp_l = pat;
        exp_l[127:0] = {r1, r0};
        #1;
        check_eq("drain_ready", 512'(req_ready), 512'(1));
        check_eq("drain_buffer", 512'(resp_rdata), 512'(exp_l));
        tick();
        check_eq("drain_no_resp", 512'(resp_cnt), 512'(n0));

        // Flush together with the last beat: straight back to IDLE, beat not stored
        n0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3100_0000; req_wdata = ~pat;
        tick();
        req_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = r3; tick();
        mem_rdata = r2; tick();
        mem_rdata = r1; tick();
        mem_rdata = r0; flush = 1'b1; tick();
        mem_rvalid = 1'b0; flush = 1'b0;
        exp_l = ~pat;
        exp_l[191:0] = {r1, r2, r3};
        #1;
        check_eq("lastflush_ready", 512'(req_ready), 512'(1));
        check_eq("lastflush_buffer", 512'(resp_rdata), 512'(exp_l));
        tick();
        check_eq("lastflush_no_resp", 512'(resp_cnt), 512'(n0));

        // Flush while the read command waits: command withdrawn, no beats expected
        n0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3200_0040; req_wdata = '0;
        tick();
        req_valid = 1'b0; mem_ready = 1'b0; flush = 1'b1;
        #1 check_eq("rdreq_flush_read", 512'(mem_read), 512'(1));
        tick();
        flush = 1'b0;
        #1;
        check_eq("rdreq_flush_read_off", 512'(mem_read), 512'(0));
        check_eq("rdreq_flush_ready", 512'(req_ready), 512'(1));
        tick();
        tick();
        check_eq("rdreq_flush_no_resp", 512'(resp_cnt), 512'(n0));

        // Fill after a drained/flushed burst must start at beat 0 again
        do_read(32'h3300_001F, line_c, 256'd0);

        // Reset in the middle of a fill
        n0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4000_0008; req_wdata = pat;
        tick();
        req_valid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = r0; tick();
        mem_rdata = r1; rst = 1'b1; tick();
        rst = 1'b0; mem_rvalid = 1'b0;
        #1;
        check_eq("midrst_ready", 512'(req_ready), 512'(1));
        check_eq("midrst_buffer", 512'(resp_rdata), 512'(0));
        check_eq("midrst_addr", 512'(resp_addr), 512'(0));
        check_eq("midrst_mem_read", 512'(mem_read), 512'(0));
        tick();
        tick();
        check_eq("midrst_no_resp", 512'(resp_cnt), 512'(n0));
        do_read(32'h4000_0008, line_b, 256'd0);

        // Wide configuration: 16 beats, two back-to-back fills exercise the wrap
        do_wide_read(32'h0000_12FF, 32'h0101_0101);
        do_wide_read(32'hABCD_EF7F, 32'h1000_0003);

        check_eq("wbeat_queue_empty", 512'(exp_q.size()), 512'(0));
        check_eq("rd_wr_exclusive", 512'(prot_err), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/burst_line_adapter.md
BURST_LINE_ADAPTER -- requirements
Module: burst_line_adapter

Interface
REQ-001 The block SHALL have parameter LINE_BITS, default 256, giving the cache line width in bits.
REQ-002 The block SHALL have parameter BEAT_BITS, default 64, giving the memory beat width; BEATS = LINE_BITS/BEAT_BITS SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter ADDR_BITS, default 32, giving the byte address width.
REQ-004 The ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  branch flush; discards any in-flight read.
- req_valid  in  1  cache request present.
- req_ready  out  1  request accepted this cycle.
- req_write  in  1  1 = writeback, 0 = fill.
- req_addr  in  ADDR_BITS  request byte address.
- req_wdata  in  LINE_BITS  writeback line.
- resp_valid  out  1  one-cycle completion pulse.
- resp_addr  out  ADDR_BITS  line-aligned address of the completed request.
- resp_rdata  out  LINE_BITS  assembled fill line.
- mem_addr  out  ADDR_BITS  memory command address.
- mem_read  out  1  read command.
- mem_write  out  1  write beat valid.
- mem_wdata  out  BEAT_BITS  write beat data.
- mem_ready  in  1  memory accepts the read command or the write beat.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  BEAT_BITS  read beat data.

Function
REQ-005 The state machine SHALL have exactly these states: IDLE, RD_REQ, RD_BEAT, WR_BEAT, DONE, DRAIN.
REQ-006 req_ready SHALL equal (state==IDLE && !flush); a request is accepted when req_valid && req_ready.
REQ-007 On acceptance the block SHALL:
- latch the line address as req_addr with the low log2(LINE_BITS/8) bits cleared;
- latch req_write and req_wdata;
- clear the beat counter;
- go to RD_REQ if req_write=0, otherwise to WR_BEAT.
REQ-008 In RD_REQ:
- mem_read=1 and mem_addr=line address;
- on mem_ready, go to RD_BEAT.
REQ-009 In RD_BEAT, each cycle with mem_rvalid SHALL write mem_rdata into line slice [cnt*BEAT_BITS +: BEAT_BITS] and increment cnt; the beat with cnt==BEATS-1 SHALL go to DONE.
REQ-010 In WR_BEAT:
- mem_write=1, mem_addr=line address, mem_wdata=latched line slice cnt;
- each cycle with mem_ready SHALL increment cnt;
- the accepted beat with cnt==BEATS-1 SHALL go to DONE;
- with mem_ready low, mem_wdata SHALL hold.
REQ-011 In DONE:
- resp_valid=1 for exactly one cycle;
- resp_addr=line address;
- resp_rdata=assembled line (for a write, the latched write line);
- next state SHALL be IDLE.
REQ-012 mem_read and mem_write SHALL never both be 1; both SHALL be 0 outside RD_REQ and WR_BEAT.
REQ-013 The beat counter SHALL be log2(BEATS) bits wide and SHALL wrap to 0 after the last beat.
REQ-014 mem_rvalid in IDLE, RD_REQ, WR_BEAT or DONE SHALL be ignored, with no change to the line buffer.
REQ-015 Flush handling by state:
- RD_REQ: return to IDLE; mem_read SHALL be deasserted the cycle after.
- RD_BEAT: go to DRAIN.
- DRAIN: absorb mem_rvalid beats without writing the buffer until the total beat count reaches BEATS, then go to IDLE with no resp_valid.
- WR_BEAT: ignored; writebacks always complete.
- DONE of a read: suppress resp_valid.
- DONE of a write: resp_valid SHALL still be asserted.
REQ-016 Flush and mem_rvalid on the same RD_BEAT cycle SHALL count that beat toward DRAIN completion; if it was the last beat, the next state SHALL be IDLE.
REQ-017 With mem_ready held at 1 and no stalls, latency SHALL be:
- read: resp_valid BEATS+2 cycles after acceptance, given beats on consecutive cycles;
- write: resp_valid BEATS+1 cycles after acceptance.

Reset
REQ-018 On rst the block SHALL set:
- state IDLE and beat counter 0;
- all outputs 0, except req_ready, which SHALL be 1 the cycle after reset deasserts;
- line buffer and latched address to 0.
REQ-019 rst SHALL take priority over flush and abort any read or write mid-operation; no resp_valid SHALL follow.

Verification
REQ-020 Read with defaults: req_addr=0x1000_0013, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> mem_addr=0x1000_0000; resp_rdata={0x44..,0x33..,0x22..,0x11..}; resp_addr=0x1000_0000; one resp_valid pulse.
REQ-021 Write with req_wdata={D3,D2,D1,D0} and mem_ready low on the 2nd beat for 3 cycles -> mem_wdata sequence D0,D1(held 3 cycles),D2,D3; resp_valid once after D3 is accepted.
REQ-022 Flush after 2 of 4 read beats -> 2 more beats absorbed, line buffer unchanged, no resp_valid, req_ready=1 the cycle after the 4th beat.
REQ-023 Flush during WR_BEAT, and flush in RD_REQ with mem_ready=0 -> write completes with resp_valid; read returns to IDLE with no beats expected.
REQ-024 rst asserted mid-RD_BEAT, then a new read -> clean IDLE; new fill contains only the new beats.
REQ-025 Parameter sweep LINE_BITS=512, BEAT_BITS=32 (BEATS=16) -> counter wraps correctly and the full line is assembled in beat order.
